// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - up/down modulo counter with load, clear, terminal-count pulse and sticky overflow
module updown_mod_counter #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf,
  input  logic             ovf_clr
);

  logic [WIDTH-1:0] step_cnt;
  logic [WIDTH-1:0] load_clamped;
  logic             boundary;
  logic             event_hit;

  // Comparisons come before any arithmetic, so cnt+1 never leaves the range.
  always_comb begin
    step_cnt = cnt;
    boundary = 1'b0;
    if (up) begin
      if (cnt >= max_val) begin
        boundary = 1'b1;
        step_cnt = (SATURATE != 0) ? max_val : '0;
      end else begin
        step_cnt = cnt + WIDTH'(1);
      end
    end else begin
      if (cnt > max_val) begin
        step_cnt = max_val;
      end else if (cnt == '0) begin
        boundary = 1'b1;
        step_cnt = (SATURATE != 0) ? '0 : max_val;
      end else begin
        step_cnt = cnt - WIDTH'(1);
      end
    end
  end

  assign load_clamped = (load_val > max_val) ? max_val : load_val;
  assign event_hit    = !clr && !load && en && boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      tc  <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      tc  <= 1'b0;
    end else if (load) begin
      cnt <= load_clamped;
      tc  <= 1'b0;
    end else if (en) begin
      cnt <= step_cnt;
      tc  <= boundary;
    end else begin
      tc  <= 1'b0;
    end
  end

  // A boundary event wins over a simultaneous ovf_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (event_hit) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - scoreboard bench for wrap and saturate instances of updown_mod_counter
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0, load = 1'b0, en = 1'b0, up = 1'b1, ovf_clr = 1'b0;
  logic [7:0] load_val = '0, max_val = '0;
  logic [7:0] cnt_w, cnt_s;
  logic       tc_w, tc_s, ovf_w, ovf_s;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit         sat;
    logic [7:0] cnt;
    bit         tc;
    bit         ovf;
    string      name;
  } exp_t;

  exp_t sb[$];
  event chk_now;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(8), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .max_val(max_val), .cnt(cnt_w), .tc(tc_w), .ovf(ovf_w),
    .ovf_clr(ovf_clr)
  );

  updown_mod_counter #(.WIDTH(8), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .max_val(max_val), .cnt(cnt_s), .tc(tc_s), .ovf(ovf_s),
    .ovf_clr(ovf_clr)
  );

  task automatic push(input bit sat, input logic [7:0] c, input bit t, input bit o, input string nm);
    exp_t e;
    e.sat = sat; e.cnt = c; e.tc = t; e.ovf = o; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic push2(input logic [7:0] cw, input bit tw, input bit ow,
                       input logic [7:0] cs, input bit ts, input bit os, input string nm);
    push(1'b0, cw, tw, ow, nm);
    push(1'b1, cs, ts, os, nm);
  endtask

  task automatic drive(input bit c, input bit l, input logic [7:0] lv, input bit e,
                       input bit u, input logic [7:0] m, input bit oc);
    clr = c; load = l; load_val = lv; en = e; up = u; max_val = m; ovf_clr = oc;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string nm, input string fld, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s %s: got %0d, expected %0d", nm, fld, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, or immediately for asynchronous-reset checks.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_now);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.sat) begin
          cmp({e.name, "/sat"}, "cnt", int'(cnt_s), int'(e.cnt));
          cmp({e.name, "/sat"}, "tc",  int'(tc_s),  int'(e.tc));
          cmp({e.name, "/sat"}, "ovf", int'(ovf_s), int'(e.ovf));
        end else begin
          cmp({e.name, "/wrap"}, "cnt", int'(cnt_w), int'(e.cnt));
          cmp({e.name, "/wrap"}, "tc",  int'(tc_w),  int'(e.tc));
          cmp({e.name, "/wrap"}, "ovf", int'(ovf_w), int'(e.ovf));
        end
      end
    end
  end

  initial begin
    int exp_wrap12[12];
    int exp_sat6[6];
    int exp_wrap6[6];
    exp_wrap12 = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    exp_sat6   = '{1, 2, 3, 3, 3, 3};
    exp_wrap6  = '{1, 2, 3, 0, 1, 2};

    #2;
    push2(8'd0, 0, 0, 8'd0, 0, 0, "reset");
    -> chk_now;
    #1 rst_n = 1'b1;

    // wrap at max_val=9, counting up from reset
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 8'd0, 1, 1, 8'd9, 0);
      push(1'b0, 8'(exp_wrap12[i]), (i == 9), (i >= 9), "up_wrap9");
    end

    // down from zero wraps to max_val
    drive(1, 0, 8'd0, 0, 1, 8'd9, 1);
    push2(8'd0, 0, 0, 8'd0, 0, 0, "clr_ovfclr");
    drive(0, 0, 8'd0, 1, 0, 8'd5, 0);
    push2(8'd5, 1, 1, 8'd0, 1, 1, "down_from0");
    drive(0, 0, 8'd0, 1, 0, 8'd5, 0);
    push2(8'd4, 0, 1, 8'd0, 1, 1, "down_next");

    // saturate at max_val=3
    drive(1, 0, 8'd0, 0, 1, 8'd3, 1);
    push2(8'd0, 0, 0, 8'd0, 0, 0, "clr2");
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 8'd0, 1, 1, 8'd3, 0);
      push2(8'(exp_wrap6[i]), (i == 3), (i >= 3), 8'(exp_sat6[i]), (i >= 3), (i >= 3), "up_max3");
    end
    drive(0, 0, 8'd0, 0, 1, 8'd3, 1);
    push2(8'd2, 0, 0, 8'd3, 0, 0, "ovf_clr_only");

    // load clamps to max_val and overrides en; clr overrides load
    drive(0, 1, 8'd200, 1, 1, 8'd100, 0);
    push2(8'd100, 0, 0, 8'd100, 0, 0, "load_clamp");
    drive(1, 1, 8'd200, 1, 1, 8'd100, 0);
    push2(8'd0, 0, 0, 8'd0, 0, 0, "clr_over_load");

    // max_val lowered below cnt: up is a boundary event, down is not
    for (int i = 0; i < 7; i++) drive(0, 0, 8'd0, 1, 1, 8'd9, 0);
    push2(8'd7, 0, 0, 8'd7, 0, 0, "count_to7");
    drive(0, 0, 8'd0, 1, 1, 8'd4, 0);
    push2(8'd0, 1, 1, 8'd4, 1, 1, "lowered_up");
    drive(1, 0, 8'd0, 0, 1, 8'd9, 1);
    push2(8'd0, 0, 0, 8'd0, 0, 0, "clr3");
    for (int i = 0; i < 7; i++) drive(0, 0, 8'd0, 1, 1, 8'd9, 0);
    drive(0, 0, 8'd0, 1, 0, 8'd4, 0);
    push2(8'd4, 0, 0, 8'd4, 0, 0, "lowered_down");

    // max_val=0: every enabled step is a boundary event
    drive(0, 0, 8'd0, 1, 1, 8'd0, 0);
    push2(8'd0, 1, 1, 8'd0, 1, 1, "max0_up");
    drive(0, 0, 8'd0, 1, 0, 8'd0, 0);
    push2(8'd0, 1, 1, 8'd0, 1, 1, "max0_down");

    // full range
    drive(1, 0, 8'd0, 0, 1, 8'd255, 1);
    push2(8'd0, 0, 0, 8'd0, 0, 0, "clr4");
    drive(0, 1, 8'd254, 0, 1, 8'd255, 0);
    push2(8'd254, 0, 0, 8'd254, 0, 0, "load254");
    drive(0, 0, 8'd0, 1, 1, 8'd255, 0);
    push2(8'd255, 0, 0, 8'd255, 0, 0, "to255");
    drive(0, 0, 8'd0, 1, 1, 8'd255, 0);
    push2(8'd0, 1, 1, 8'd255, 1, 1, "full_wrap");

    // asynchronous reset mid-count
    drive(1, 0, 8'd0, 0, 1, 8'd6, 1);
    push2(8'd0, 0, 0, 8'd0, 0, 0, "clr5");
    drive(0, 0, 8'd0, 1, 0, 8'd6, 0);
    push2(8'd6, 1, 1, 8'd0, 1, 1, "pre_reset");
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    push2(8'd0, 0, 0, 8'd0, 0, 0, "async_reset");
    -> chk_now;
    drive(0, 0, 8'd0, 1, 1, 8'd6, 0);
    push2(8'd0, 0, 0, 8'd0, 0, 0, "reset_hold");
    rst_n = 1'b1;
    drive(0, 0, 8'd0, 1, 1, 8'd6, 0);
    push2(8'd1, 0, 0, 8'd1, 0, 0, "after_reset");

    drive(0, 0, 8'd0, 0, 1, 8'd6, 0);
    repeat (2) @(negedge clk);
    #1;
    cmp("scoreboard_drain", "pending", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised successor to the team's 4-bit synchronous up-counter.
- Configurable width; runtime direction, modulus (0..max_val), parallel load and synchronous clear.
- Compile-time wrap or saturate mode; registered terminal-count pulse and sticky overflow flag.
- Used as a general event/timebase counter in datapath and control blocks.

Parameters:
WIDTH, 8, counter width in bits (>=2)
SATURATE, 0, 0 = wrap at boundary; 1 = hold at boundary

Ports:
clk  input  1  posedge clock
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear, highest priority
load  input  1  synchronous parallel load
load_val  input  WIDTH  value for load
en  input  1  count enable, one step per cycle when high
up  input  1  direction: 1 = increment, 0 = decrement
max_val  input  WIDTH  inclusive upper bound of count range
cnt  output  WIDTH  registered count value
tc  output  1  registered terminal-count pulse
ovf  output  1  sticky boundary-event flag
ovf_clr  input  1  synchronous clear of ovf

Behaviour:
- Reset: rst_n low asynchronously forces cnt=0, tc=0, ovf=0. Outputs hold while rst_n is low. Normal operation resumes on the first clk edge after deassertion.
- All other updates occur on posedge clk. Latency is 1 cycle: cnt reflects the operation sampled on the same edge.
- Priority per edge is clr > load > en. Idle holds cnt.
- clr: cnt<=0, tc<=0. ovf is unaffected by clr.
- load: cnt<=min(load_val, max_val), tc<=0. en is ignored in that cycle.
- en, up=1:
  - cnt<max_val: cnt<=cnt+1.
  - cnt>=max_val is a boundary event: wrap mode cnt<=0; saturate mode cnt<=max_val.
- en, up=0:
  - cnt>max_val (max_val lowered at runtime): cnt<=max_val. Not a boundary event.
  - 0<cnt<=max_val: cnt<=cnt-1.
  - cnt==0 is a boundary event: wrap mode cnt<=max_val; saturate mode cnt<=0.
- tc<=1 on an edge whose enabled step was a boundary event, else tc<=0. tc is therefore a one-cycle pulse per event; in saturate mode it repeats every enabled cycle while blocked.
- ovf is set on any boundary event and cleared by ovf_clr. A simultaneous set and clear leaves ovf=1.
- max_val=0: cnt stays 0; every enabled step is a boundary event.
- max_val=all-ones: full-range counter. No arithmetic overflow is possible internally, since the comparison precedes the increment.
- All arithmetic is unsigned WIDTH-bit. No X propagation from unused load_val when load=0.

Test Plan:
- WIDTH=8, wrap, max_val=9, up=1, en held 12 cycles from reset -> cnt 1..9, 0, 1, 2; tc=1 only in the cycle cnt shows 0; ovf=1 thereafter.
- Wrap, max_val=5, cnt=0, up=0, en one cycle -> cnt=5, tc=1. Next cycle en -> cnt=4, tc=0.
- SATURATE=1, max_val=3, up=1, en 6 cycles -> cnt 1, 2, 3, 3, 3, 3; tc high on the last 3 cycles; ovf_clr pulsed with no event -> ovf=0.
- load=1, load_val=200, max_val=100, en=1 same cycle -> cnt=100 (clamped), tc=0. Then clr=1 and load=1 together -> cnt=0.
- Count to cnt=7 with max_val=9, then set max_val=4: up step -> cnt=0, tc=1 (wrap); repeat scenario with down step -> cnt=4, tc=0.
- rst_n asserted mid-count (cnt=6, tc=1) between clock edges -> cnt=0, tc=0, ovf=0 immediately. After release, first enabled up edge -> cnt=1.
